alu_ctrl_issue: RTL and testbench
=================================

Name: alu_ctrl_issue

Overview:
- Producer end of the ALU control interface. Takes decoded instruction fields (ALUOp, funct) plus two operands from the ID stage over a valid/ready handshake.
- Translates them into the 4-bit ALU_ctrl code and presents ctrl plus operands to the EX-stage ALU through a registered output with a one-entry skid buffer.
- Sits between ID and EX. Breaks the combinational path into the ALU and absorbs EX back-pressure without bubbles.
- Also counts illegal R-type funct codes for the status path.

Parameters:
- DATA_W, 32, operand width.
- CNT_W, 8, width of the saturating illegal-op counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  ID has a valid request.
- in_ready  output  1  block can accept a request this cycle.
- in_alu_op  input  2  class code: 00 load/store, 01 branch-equal, 10 R-type, 11 or-immediate.
- in_funct  input  6  R-type funct field; ignored unless in_alu_op=10.
- in_operand_1  input  DATA_W  first ALU operand.
- in_operand_2  input  DATA_W  second ALU operand.
- out_valid  output  1  EX-side request valid.
- out_ready  input  1  EX accepts the request this cycle.
- ALU_ctrl  output  4  ALU operation code.
- ALU_operand_1  output  DATA_W  registered operand 1.
- ALU_operand_2  output  DATA_W  registered operand 2.
- out_illegal  output  1  request carries an unsupported funct.
- illegal_cnt  output  CNT_W  saturating count of accepted illegal requests.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: out_valid=0, in_ready=1, ALU_ctrl=4'b0000, operands=0, out_illegal=0, illegal_cnt=0, skid entry empty.
- Reset mid-transfer: any held or skidded request is dropped. No partial outputs.
- Decode (combinational, on input side):
  - alu_op 00 -> 0010 (add).
  - alu_op 01 -> 0110 (sub).
  - alu_op 11 -> 0001 (or).
  - alu_op 10 with funct 100000 -> 0010 (add); 100010 -> 0110 (sub); 100100 -> 0000 (and); 100101 -> 0001 (or); 101010 -> 0111 (slt); 100111 -> 1100 (nor).
  - Any other funct with alu_op 10 -> ALU_ctrl=1111 and illegal=1.
- Handshakes: input accept = in_valid & in_ready. Output transfer = out_valid & out_ready. Output payload is stable while out_valid=1 and out_ready=0.
- Latency: accepted request appears at the output on the next edge (1 cycle) when the output register is empty or transferring.
- Skid state machine, two states:
  - PASS: skid empty, in_ready=1.
  - SKID: skid full, in_ready=0.
  - PASS->SKID when a request is accepted while out_valid=1 and out_ready=0. The decoded request goes into the skid register.
  - SKID->PASS when out_ready=1. The skid entry moves into the output register in the same edge.
- in_ready is a register output, never combinationally dependent on out_ready.
- Simultaneous accept and output transfer in PASS: the new request loads the output register directly. out_valid stays 1, so throughput is 1 per cycle.
- No accept and output transfer: out_valid falls to 0.
- Ordering: strict FIFO. The skid entry always issues before any later request.
- illegal_cnt increments by 1 on each accepted request with illegal=1. It is counted at accept, not at issue. It saturates at 2^CNT_W-1 (255) and never wraps.
- Operands pass through unmodified. No arithmetic is performed here.

Decomposition:
- Shared package alu_pkg holds:
  - ALU_ctrl constants: ALU_AND=0000, ALU_OR=0001, ALU_ADD=0010, ALU_SUB=0110, ALU_SLT=0111, ALU_NOR=1100, ALU_ILL=1111.
  - ALUOp class constants.
  - funct constants.
  - A payload struct {ctrl, op1, op2, illegal}.
- One natural sub-module: alu_ctrl_decode, the purely combinational alu_op/funct -> {ctrl, illegal} decoder, reusable by the single-cycle datapath.

Test Plan:
- Reset: assert rst_n=0 mid-stream with out_valid=1 -> out_valid=0, in_ready=1, illegal_cnt=0 immediately. No stale request issues after release.
- Decode sweep with out_ready=1:
  - alu_op=10 and funct 100000/100010/100100/100101/101010/100111 -> ALU_ctrl 0010/0110/0000/0001/0111/1100 one cycle later.
  - alu_op 00/01/11 -> 0010/0110/0001.
- Back-pressure: stream A(op1=5), B(op1=7), C with out_ready=0 for 3 cycles:
  - A held stable, B in skid, in_ready=0, C stalled.
  - Release out_ready -> A, B, C issue in order, one per cycle.
- Full throughput: 100 back-to-back requests with out_ready=1 -> out_valid continuously 1 after the first cycle, in_ready never drops.
- Illegal: alu_op=10, funct=000000 -> ALU_ctrl=1111, out_illegal=1, illegal_cnt +1.
- Saturation: 300 illegal requests -> illegal_cnt=255.
- Random valid/ready toggling, 10k requests: a scoreboard matches order and payload, and no request is lost or duplicated.

Source files
------------

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU control path: ALU_ctrl operation codes,
// ALUOp class codes, R-type funct codes, the request payload carried from
// ID to EX, and the skid-buffer state type.
// -----------------------------------------------------------------------------
package alu_pkg;

  // Widest operand the payload struct can carry.
  localparam int ALU_DATA_W = 32;

  // ALU_ctrl operation codes
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_ILL = 4'b1111;

  // ALUOp instruction classes
  localparam logic [1:0] ALUOP_MEM   = 2'b00;
  localparam logic [1:0] ALUOP_BEQ   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ORI   = 2'b11;

  // R-type funct codes
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;
  localparam logic [5:0] FUNCT_NOR = 6'b100111;

  // One decoded request as presented to the EX-stage ALU.
  typedef struct packed {
    logic [3:0]            ctrl;
    logic [ALU_DATA_W-1:0] op1;
    logic [ALU_DATA_W-1:0] op2;
    logic                  illegal;
  } alu_payload_t;

  // PASS: skid register empty, accepting. SKID: skid register holds a request.
  typedef enum logic {
    ST_PASS = 1'b0,
    ST_SKID = 1'b1
  } skid_state_e;

endpackage

// File: rtl/alu_ctrl_decode.sv
// -----------------------------------------------------------------------------
// alu_ctrl_decode
// Purely combinational ALUOp/funct -> ALU_ctrl decoder. Shared with the
// single-cycle datapath.
// Ports:
//   alu_op  in  2  instruction class
//   funct   in  6  R-type funct field (only looked at for R-type)
//   ctrl    out 4  ALU operation code
//   illegal out 1  R-type with an unsupported funct
// -----------------------------------------------------------------------------
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [3:0] ctrl,
  output logic       illegal
);

  // Unsupported R-type functs map to ALU_ILL so EX can spot them without
  // also having to look at the illegal flag.
  always_comb begin
    ctrl    = ALU_ADD;
    illegal = 1'b0;
    case (alu_op)
      ALUOP_MEM: ctrl = ALU_ADD;
      ALUOP_BEQ: ctrl = ALU_SUB;
      ALUOP_ORI: ctrl = ALU_OR;
      default: begin
        case (funct)
          FUNCT_ADD: ctrl = ALU_ADD;
          FUNCT_SUB: ctrl = ALU_SUB;
          FUNCT_AND: ctrl = ALU_AND;
          FUNCT_OR:  ctrl = ALU_OR;
          FUNCT_SLT: ctrl = ALU_SLT;
          FUNCT_NOR: ctrl = ALU_NOR;
          default: begin
            ctrl    = ALU_ILL;
            illegal = 1'b1;
          end
        endcase
      end
    endcase
  end

endmodule

// File: rtl/alu_ctrl_issue.sv
// -----------------------------------------------------------------------------
// alu_ctrl_issue
// Producer end of the ALU control interface. Decodes ALUOp/funct from ID,
// registers ctrl plus operands toward EX, and uses a one-entry skid buffer
// so EX back-pressure never creates bubbles and in_ready stays a pure
// register output. Also counts accepted illegal R-type requests.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   in_valid/in_ready           ID-side handshake
//   in_alu_op, in_funct         decoded instruction fields
//   in_operand_1/2              operands from ID
//   out_valid/out_ready         EX-side handshake
//   ALU_ctrl, ALU_operand_1/2   registered request to EX
//   out_illegal                 registered request has an unsupported funct
//   illegal_cnt                 saturating count of accepted illegal requests
// -----------------------------------------------------------------------------
module alu_ctrl_issue
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_alu_op,
  input  logic [5:0]        in_funct,
  input  logic [DATA_W-1:0] in_operand_1,
  input  logic [DATA_W-1:0] in_operand_2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        ALU_ctrl,
  output logic [DATA_W-1:0] ALU_operand_1,
  output logic [DATA_W-1:0] ALU_operand_2,
  output logic              out_illegal,
  output logic [CNT_W-1:0]  illegal_cnt
);

  logic [3:0]   dec_ctrl;
  logic         dec_illegal;
  logic         accept;
  alu_payload_t in_payload;
  alu_payload_t out_q, out_d;
  alu_payload_t skid_q, skid_d;
  logic         out_valid_q, out_valid_d;
  skid_state_e  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  alu_ctrl_decode u_decode (
    .alu_op  (in_alu_op),
    .funct   (in_funct),
    .ctrl    (dec_ctrl),
    .illegal (dec_illegal)
  );

  // in_ready comes straight from the state flop, so it never depends on
  // out_ready combinationally.
  assign in_ready = (state_q == ST_PASS);
  assign accept   = in_valid & in_ready;

  always_comb begin
    in_payload.ctrl    = dec_ctrl;
    in_payload.op1     = ALU_DATA_W'(in_operand_1);
    in_payload.op2     = ALU_DATA_W'(in_operand_2);
    in_payload.illegal = dec_illegal;
  end

  // Skid control. A request arriving while the output is stalled parks in
  // the skid register; when EX frees the output, the skid entry moves up in
  // the same edge so it always issues before anything accepted later.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_d       = out_q;
    skid_d      = skid_q;
    case (state_q)
      ST_PASS: begin
        if (accept) begin
          if (!out_valid_q || out_ready) begin
            out_d       = in_payload;
            out_valid_d = 1'b1;
          end else begin
            skid_d  = in_payload;
            state_d = ST_SKID;
          end
        end else if (out_ready) begin
          out_valid_d = 1'b0;
        end
      end
      ST_SKID: begin
        if (out_ready) begin
          out_d   = skid_q;
          state_d = ST_PASS;
        end
      end
      default: state_d = ST_PASS;
    endcase
  end

  // Illegal requests are counted when ID hands them over, not when they
  // reach EX; the count sticks at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (accept && dec_illegal && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_PASS;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      skid_q      <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      skid_q      <= skid_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign ALU_ctrl      = out_q.ctrl;
  assign ALU_operand_1 = out_q.op1[DATA_W-1:0];
  assign ALU_operand_2 = out_q.op2[DATA_W-1:0];
  assign out_illegal   = out_q.illegal;
  assign illegal_cnt   = cnt_q;

endmodule

// File: tb/tb_alu_ctrl_issue.sv
// -----------------------------------------------------------------------------
// tb_alu_ctrl_issue
// Scoreboard bench for alu_ctrl_issue. Accepted requests push their expected
// payload (from a table-driven reference decoder); a monitor pops and
// compares on every EX-side transfer.
// -----------------------------------------------------------------------------
module tb_alu_ctrl_issue;

  localparam int DATA_W  = 32;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = 255;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [1:0]        in_alu_op = '0;
  logic [5:0]        in_funct = '0;
  logic [DATA_W-1:0] in_operand_1 = '0;
  logic [DATA_W-1:0] in_operand_2 = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [3:0]        ALU_ctrl;
  logic [DATA_W-1:0] ALU_operand_1;
  logic [DATA_W-1:0] ALU_operand_2;
  logic              out_illegal;
  logic [CNT_W-1:0]  illegal_cnt;

  alu_ctrl_issue #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_alu_op     (in_alu_op),
    .in_funct      (in_funct),
    .in_operand_1  (in_operand_1),
    .in_operand_2  (in_operand_2),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .ALU_ctrl      (ALU_ctrl),
    .ALU_operand_1 (ALU_operand_1),
    .ALU_operand_2 (ALU_operand_2),
    .out_illegal   (out_illegal),
    .illegal_cnt   (illegal_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  ctrl;
    logic        ill;
    logic [31:0] op1;
    logic [31:0] op2;
    int          acc_cycle;
  } exp_t;

  // Legal R-type funct codes and the ALU operation each one selects.
  localparam logic [5:0] LEGAL_F [6] = '{6'b100000, 6'b100010, 6'b100100,
                                         6'b100101, 6'b101010, 6'b100111};
  localparam logic [3:0] LEGAL_C [6] = '{4'b0010, 4'b0110, 4'b0000,
                                         4'b0001, 4'b0111, 4'b1100};

  exp_t        sb[$];
  int          log_cycle[$];
  logic [31:0] log_op1[$];
  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;
  int cycle = 0;
  int ready_mode = 0;      // 0 always ready, 1 random, 2 stalled
  logic lat_check = 1'b0;
  logic tp_phase = 1'b0;
  logic tp_seen = 1'b0;
  int tp_gaps = 0;
  int tp_valid_cycles = 0;
  int stall_waits = 0;

  always @(posedge clk) cycle++;

  task automatic checkOutput(input string name, input logic [95:0] actual,
                             input logic [95:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Reference decoder: class codes first, then a table search for R-type.
  function automatic void refDecode(input logic [1:0] op, input logic [5:0] f,
                                    output logic [3:0] c, output logic ill);
    c   = 4'b1111;
    ill = 1'b1;
    if (op == 2'b00) begin c = 4'b0010; ill = 1'b0; end
    else if (op == 2'b01) begin c = 4'b0110; ill = 1'b0; end
    else if (op == 2'b11) begin c = 4'b0001; ill = 1'b0; end
    else begin
      for (int i = 0; i < 6; i++) begin
        if (LEGAL_F[i] == f) begin c = LEGAL_C[i]; ill = 1'b0; end
      end
    end
  endfunction

  function automatic void pushExpected(input logic [1:0] op, input logic [5:0] f,
                                       input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    refDecode(op, f, e.ctrl, e.ill);
    e.op1 = a;
    e.op2 = b;
    e.acc_cycle = cycle;
    sb.push_back(e);
    if (e.ill && exp_cnt < CNT_MAX) exp_cnt++;
  endfunction

  // EX-side ready generator.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: scoreboard pops on each transfer, and a stalled payload must
  // stay put until it transfers.
  initial begin
    logic stall_prev;
    logic [68:0] held;
    exp_t e;
    stall_prev = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          checkOutput("hold_valid", 96'(out_valid), 96'(1));
          checkOutput("hold_payload",
                      96'({ALU_ctrl, out_illegal, ALU_operand_1, ALU_operand_2}),
                      96'(held));
        end
        if (tp_phase) begin
          if (out_valid) begin tp_seen = 1'b1; tp_valid_cycles++; end
          else if (tp_seen) tp_gaps++;
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_output: got op1=0x%0h, expected no output",
                     ALU_operand_1);
          end else begin
            e = sb.pop_front();
            checkOutput("sb_payload",
                        96'({ALU_ctrl, out_illegal, ALU_operand_1, ALU_operand_2}),
                        96'({e.ctrl, e.ill, e.op1, e.op2}));
            if (lat_check) checkOutput("latency", 96'(cycle), 96'(e.acc_cycle + 1));
          end
          log_cycle.push_back(cycle);
          log_op1.push_back(ALU_operand_1);
        end
        stall_prev = out_valid && !out_ready;
        held = {ALU_ctrl, out_illegal, ALU_operand_1, ALU_operand_2};
      end
    end
  end

  // Offer one request and hold it until accepted (bounded). Call at posedge+1;
  // returns at posedge+1 after the accepting edge.
  task automatic applyStimulus(input logic [1:0] op, input logic [5:0] f,
                               input logic [31:0] a, input logic [31:0] b);
    int waited;
    waited = 0;
    in_valid = 1'b1;
    in_alu_op = op;
    in_funct = f;
    in_operand_1 = a;
    in_operand_2 = b;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        pushExpected(op, f, a, b);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
      waited++;
      stall_waits++;
      if (waited >= 50) begin
        checks++;
        errors++;
        $display("[TB] FAIL accept_timeout: got no accept in %0d cycles, expected accept", waited);
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic setReady(input int m);
    @(negedge clk);
    ready_mode = m;
    @(posedge clk);
    #1;
  endtask

  task automatic drainQueue();
    in_valid = 1'b0;
    setReady(0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !out_valid) break;
    end
    checkOutput("drain_empty", 96'(sb.size()), 96'(0));
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] randIllegalFunct();
    logic [5:0] f;
    logic [3:0] c;
    logic ill;
    do begin
      f = 6'($urandom);
      refDecode(2'b10, f, c, ill);
    end while (!ill);
    return f;
  endfunction

  initial begin
    int lc0;
    logic [1:0] op;
    logic [5:0] f;

    // Power-on reset
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", 96'(out_valid), 96'(0));
    checkOutput("rst_in_ready", 96'(in_ready), 96'(1));
    checkOutput("rst_ctrl", 96'(ALU_ctrl), 96'(0));
    checkOutput("rst_operands", 96'({ALU_operand_1, ALU_operand_2}), 96'(0));
    checkOutput("rst_illegal", 96'(out_illegal), 96'(0));
    checkOutput("rst_cnt", 96'(illegal_cnt), 96'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Decode sweep, always ready
    lat_check = 1'b1;
    for (int i = 0; i < 6; i++) applyStimulus(2'b10, LEGAL_F[i], $urandom, $urandom);
    applyStimulus(2'b00, 6'($urandom), $urandom, $urandom);
    applyStimulus(2'b01, 6'($urandom), $urandom, $urandom);
    applyStimulus(2'b11, 6'($urandom), $urandom, $urandom);
    drainQueue();

    // Back-pressure: A held, B skidded, C stalled, then A/B/C in order
    lat_check = 1'b0;
    setReady(2);
    lc0 = log_op1.size();
    applyStimulus(2'b00, 6'd0, 32'd5, 32'd1);
    applyStimulus(2'b00, 6'd0, 32'd7, 32'd2);
    in_valid = 1'b1;
    in_alu_op = 2'b01;
    in_operand_1 = 32'd9;
    in_operand_2 = 32'd3;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("bp_in_ready", 96'(in_ready), 96'(0));
      checkOutput("bp_hold_a", 96'(ALU_operand_1), 96'(5));
      if (k == 2) ready_mode = 0;
      @(posedge clk);
      #1;
    end
    applyStimulus(2'b01, 6'd0, 32'd9, 32'd3);
    drainQueue();
    checkOutput("bp_count", 96'(log_op1.size() - lc0), 96'(3));
    if (log_op1.size() - lc0 == 3) begin
      checkOutput("bp_order", 96'({log_op1[lc0], log_op1[lc0+1], log_op1[lc0+2]}),
                  96'({32'd5, 32'd7, 32'd9}));
      checkOutput("bp_issue_span", 96'(log_cycle[lc0+2] - log_cycle[lc0]), 96'(2));
    end

    // Full throughput: 100 back-to-back requests
    lat_check = 1'b1;
    stall_waits = 0;
    tp_gaps = 0;
    tp_valid_cycles = 0;
    tp_seen = 1'b0;
    tp_phase = 1'b1;
    for (int i = 0; i < 100; i++) begin
      int li;
      li = $urandom_range(0, 5);
      applyStimulus(2'b10, LEGAL_F[li], $urandom, $urandom);
    end
    tp_phase = 1'b0;
    drainQueue();
    checkOutput("tp_in_ready_drops", 96'(stall_waits), 96'(0));
    checkOutput("tp_valid_gaps", 96'(tp_gaps), 96'(0));
    checkOutput("tp_valid_cycles", 96'(tp_valid_cycles), 96'(99));

    // Single illegal request
    applyStimulus(2'b10, 6'b000000, 32'hDEAD, 32'hBEEF);
    drainQueue();
    checkOutput("illegal_cnt_one", 96'(illegal_cnt), 96'(1));

    // Saturation
    lat_check = 1'b0;
    for (int i = 0; i < 300; i++) applyStimulus(2'b10, randIllegalFunct(), $urandom, $urandom);
    drainQueue();
    checkOutput("illegal_cnt_sat", 96'(illegal_cnt), 96'(255));
    checkOutput("illegal_cnt_model", 96'(illegal_cnt), 96'(exp_cnt));

    // Reset mid-stream with A held and B in the skid register
    setReady(2);
    applyStimulus(2'b00, 6'd0, 32'h11, 32'h22);
    applyStimulus(2'b01, 6'd0, 32'h33, 32'h44);
    #2;
    checkOutput("pre_reset_valid", 96'(out_valid), 96'(1));
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_out_valid", 96'(out_valid), 96'(0));
    checkOutput("mid_rst_in_ready", 96'(in_ready), 96'(1));
    checkOutput("mid_rst_cnt", 96'(illegal_cnt), 96'(0));
    checkOutput("mid_rst_ctrl", 96'(ALU_ctrl), 96'(0));
    sb.delete();
    exp_cnt = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ready_mode = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput("no_stale_output", 96'(out_valid), 96'(0));
    end
    @(posedge clk);
    #1;

    // Random traffic, random EX back-pressure
    setReady(1);
    for (int i = 0; i < 10000; i++) begin
      op = 2'($urandom);
      if ($urandom_range(0, 1) == 1) f = LEGAL_F[$urandom_range(0, 5)];
      else f = 6'($urandom);
      applyStimulus(op, f, $urandom, $urandom);
      if ($urandom_range(0, 9) >= 7) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    drainQueue();
    checkOutput("rand_illegal_cnt", 96'(illegal_cnt), 96'(exp_cnt));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got no completion by %0t, expected completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
